// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-port register file and its debug FSM.
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } dbg_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/reg_file_dbg_fsm.sv
// Debug-port arbiter: grants a debug access only when the core is not writing,
// then pulses dbg_ack for one cycle and waits for the requester to drop dbg_req.
module reg_file_dbg_fsm
  import reg_file_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dbg_req,
  input  logic       wr_en,
  output logic       grant,
  output logic       dbg_ack,
  output dbg_state_t state
);

  // Handshake: dbg_req is held high (with stable dbg_we/addr/wdata) until
  // dbg_ack; dbg_ack is a single registered pulse; a new request is only
  // accepted after dbg_req has been seen low at least once.
  assign grant = (state == IDLE) && dbg_req && !wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dbg_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dbg_ack <= 1'b0;
          if (grant) begin
            state   <= ACK;
            dbg_ack <= 1'b1;
          end
        end
        ACK: begin
          dbg_ack <= 1'b0;
          state   <= dbg_req ? HOLD : IDLE;
        end
        HOLD: begin
          dbg_ack <= 1'b0;
          if (!dbg_req) state <= IDLE;
        end
        default: begin
          dbg_ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional write bypass, per-register
// busy bits for outstanding loads, and a req/ack debug access port.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRP    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NRP-1:0][AW-1:0]    rd_addr,
  output logic [NRP-1:0][XLEN-1:0]  rd_data,
  output logic [NRP-1:0]            rd_busy,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [XLEN-1:0]           wr_data,
  input  logic                      busy_set,
  input  logic [AW-1:0]             busy_addr,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [AW-1:0]             dbg_addr,
  input  logic [XLEN-1:0]           dbg_wdata,
  output logic                      dbg_ack,
  output logic [XLEN-1:0]           dbg_rdata,
  output dbg_state_t                dbg_state
);

  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy;
  logic             dbg_grant;

  reg_file_dbg_fsm u_dbg_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .dbg_req (dbg_req),
    .wr_en   (wr_en),
    .grant   (dbg_grant),
    .dbg_ack (dbg_ack),
    .state   (dbg_state)
  );

  // Entry 0 is only ever written by reset, so it stays hard-wired to zero.
  // Grant excludes wr_en, so core and debug writes never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_en && wr_addr == AW'(r))
          mem[r] <= wr_data;
        else if (dbg_grant && dbg_we && dbg_addr == AW'(r))
          mem[r] <= dbg_wdata;
      end
    end
  end

  // A load issued to the register being written back this cycle stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (busy_set && busy_addr == AW'(r))
          busy[r] <= 1'b1;
        else if (wr_en && wr_addr == AW'(r))
          busy[r] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dbg_rdata <= '0;
    else if (dbg_grant && !dbg_we)
      dbg_rdata <= mem[dbg_addr];
  end

  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      rd_data[i] = mem[rd_addr[i]];
      rd_busy[i] = busy[rd_addr[i]];
      if (rd_addr[i] == AW'(REG_ZERO)) begin
        rd_data[i] = '0;
        rd_busy[i] = 1'b0;
      end else if (BYPASS != 0 && wr_en && wr_addr == rd_addr[i]) begin
        rd_data[i] = wr_data;
        rd_busy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios plus randomized traffic, with a
// bypass and a non-bypass instance checked against an array-based model.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRP   = 2;
  localparam int AW    = $clog2(NREGS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NRP-1:0][AW-1:0]   rd_addr;
  logic [NRP-1:0][XLEN-1:0] rd_data_a, rd_data_b;
  logic [NRP-1:0]           rd_busy_a, rd_busy_b;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [XLEN-1:0]          wr_data;
  logic                     busy_set;
  logic [AW-1:0]            busy_addr;
  logic                     dbg_req, dbg_we;
  logic [AW-1:0]            dbg_addr;
  logic [XLEN-1:0]          dbg_wdata;
  logic                     dbg_ack_a, dbg_ack_b;
  logic [XLEN-1:0]          dbg_rdata_a, dbg_rdata_b;
  dbg_state_t               dbg_state_a, dbg_state_b;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack_a), .dbg_rdata(dbg_rdata_a), .dbg_state(dbg_state_a)
  );

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack_b), .dbg_rdata(dbg_rdata_b), .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];
  bit              m_served;   // request already answered, waiting for req to drop
  bit              m_ack;      // ack expected in the current cycle
  logic [XLEN-1:0] m_rdata;
  logic [XLEN-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_served = 1'b0;
    m_ack    = 1'b0;
    m_rdata  = '0;
    exp_q.delete();
  endtask

  function automatic logic [XLEN-1:0] exp_data(bit byp, logic [AW-1:0] a);
    if (a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(bit byp, logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    busy_set = 0; busy_addr = '0;
    for (int i = 0; i < NRP; i++) rd_addr[i] = '0;
  endtask

  // Inputs are applied just after a falling edge; this checks the combinational
  // view, advances one clock, updates the model and checks the registered view.
  task automatic step();
    bit grant, grant_rd;
    logic [XLEN-1:0] v;
    #1;
    for (int i = 0; i < NRP; i++) begin
      check($sformatf("rd_data_a[%0d]", i), rd_data_a[i], exp_data(1'b1, rd_addr[i]));
      check($sformatf("rd_data_b[%0d]", i), rd_data_b[i], exp_data(1'b0, rd_addr[i]));
      check($sformatf("rd_busy_a[%0d]", i), rd_busy_a[i], exp_busy(1'b1, rd_addr[i]));
      check($sformatf("rd_busy_b[%0d]", i), rd_busy_b[i], exp_busy(1'b0, rd_addr[i]));
    end
    grant    = !m_served && dbg_req && !wr_en;
    grant_rd = grant && !dbg_we;
    @(posedge clk);
    if (grant_rd) begin
      v = m_mem[dbg_addr];
      exp_q.push_back(v);
      m_rdata = v;
    end
    if (grant && dbg_we && dbg_addr != 0) m_mem[dbg_addr] = dbg_wdata;
    if (wr_en && wr_addr != 0) begin
      m_mem[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
    if (grant) m_served = 1'b1;
    else if (!dbg_req) m_served = 1'b0;
    m_ack = grant;
    @(negedge clk);
    check("dbg_ack_a", dbg_ack_a, m_ack);
    check("dbg_ack_b", dbg_ack_b, m_ack);
    if (grant_rd && exp_q.size() > 0) check("dbg_rdata_ack", dbg_rdata_a, exp_q.pop_front());
    check("dbg_rdata_a", dbg_rdata_a, m_rdata);
    check("dbg_rdata_b", dbg_rdata_b, m_rdata);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREGS - 1));
  endfunction

  // ---------------- stimulus ----------------
  bit acked;

  initial begin
    set_idle();
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_ack", dbg_ack_a, 1'b0);
    check("rst_rdata", dbg_rdata_a, '0);
    check("rst_state", 64'(dbg_state_a), 64'(IDLE));
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd31;
    step();

    // core write then read back; x0 ignores writes
    set_idle(); wr_en = 1; wr_addr = 3; wr_data = 10;
    step();
    set_idle(); rd_addr[0] = 3;
    #1 check("x3_read", rd_data_a[0], 10);
    step();
    set_idle(); wr_en = 1; wr_addr = 0; wr_data = 77;
    step();
    set_idle(); rd_addr[0] = 0;
    #1 check("x0_read", rd_data_a[0], 0);
    step();

    // same-cycle bypass versus stored value
    set_idle(); wr_en = 1; wr_addr = 5; wr_data = 42; rd_addr[1] = 5;
    #1;
    check("bypass_on", rd_data_a[1], 42);
    check("bypass_off", rd_data_b[1], 0);
    step();

    // busy bits
    set_idle(); busy_set = 1; busy_addr = 7;
    step();
    set_idle(); rd_addr[0] = 7;
    #1 check("busy_set_x7", rd_busy_a[0], 1);
    step();
    set_idle(); wr_en = 1; wr_addr = 7; wr_data = 5; rd_addr[0] = 7;
    #1;
    check("busy_bypass_on", rd_busy_a[0], 0);
    check("busy_bypass_off", rd_busy_b[0], 1);
    step();
    set_idle(); rd_addr[0] = 7;
    #1 check("busy_clr_x7", rd_busy_b[0], 0);
    step();
    set_idle(); busy_set = 1; busy_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 6;
    step();
    set_idle(); rd_addr[0] = 7;
    #1 check("busy_set_wins", rd_busy_a[0], 1);
    step();

    // debug write x9 <- 60, then debug read x9
    set_idle(); dbg_req = 1; dbg_we = 1; dbg_addr = 9; dbg_wdata = 60;
    step();
    check("dwr_ack", dbg_ack_a, 1);
    dbg_req = 0;
    step();
    check("dwr_ack_drop", dbg_ack_a, 0);
    dbg_req = 1; dbg_we = 0; dbg_addr = 9;
    step();
    check("drd_ack", dbg_ack_a, 1);
    check("drd_data", dbg_rdata_a, 60);
    dbg_req = 0; rd_addr[0] = 9;
    #1 check("x9_core_read", rd_data_a[0], 60);
    step();

    // core write starves debug for three cycles
    set_idle(); dbg_req = 1; dbg_we = 0; dbg_addr = 3;
    wr_en = 1; wr_addr = 4; wr_data = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("starve_no_ack", dbg_ack_a, 0);
    end
    wr_en = 0;
    step();
    check("starve_ack", dbg_ack_a, 1);
    check("starve_rdata", dbg_rdata_a, 10);
    dbg_req = 0;
    step();

    // randomized traffic
    acked = 0;
    for (int c = 0; c < 600; c++) begin
      if (!dbg_req) begin
        if ($urandom_range(0, 2) == 0) begin
          dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = rand_addr(); dbg_wdata = $urandom; acked = 0;
        end
      end else begin
        if (m_ack) acked = 1;
        if (acked && $urandom_range(0, 1) == 1) dbg_req = 0;
      end
      wr_en = ($urandom_range(0, 2) == 0);
      wr_addr = rand_addr(); wr_data = $urandom;
      busy_set = ($urandom_range(0, 3) == 0);
      busy_addr = rand_addr();
      for (int i = 0; i < NRP; i++) rd_addr[i] = rand_addr();
      step();
    end
    set_idle(); dbg_req = 0;
    step();
    step();

    // make sure state is non-trivial, then reset during the ACK cycle
    set_idle(); busy_set = 1; busy_addr = 13; wr_en = 1; wr_addr = 14; wr_data = 99;
    step();
    set_idle(); dbg_req = 1; dbg_we = 1; dbg_addr = 12; dbg_wdata = 32'h55;
    step();
    check("pre_rst_ack", dbg_ack_a, 1);
    #2 rst_n = 0; dbg_req = 0;
    #1;
    check("mid_rst_ack_a", dbg_ack_a, 0);
    check("mid_rst_ack_b", dbg_ack_b, 0);
    check("mid_rst_state", 64'(dbg_state_a), 64'(IDLE));
    check("mid_rst_rdata", dbg_rdata_a, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int r = 0; r < NREGS; r += NRP) begin
      for (int i = 0; i < NRP; i++) rd_addr[i] = AW'(r + i);
      #1;
      check("post_rst_data", rd_data_b[0], 0);
      check("post_rst_busy", rd_busy_b[1], 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the next-generation RISC-V core. It replaces the fixed 2-read/1-write register file and adds three things:
- configurable write-to-read bypass;
- per-register busy (scoreboard) bits for multi-cycle loads;
- a debug access port with a req/ack handshake, so benches and debug logic read/write registers without hierarchical forcing.

It sits between decode (read ports, busy query) and writeback (write port, busy clear).

## Interface
- `XLEN`, 32, register width in bits
- `NREGS`, 32, number of registers; power of two, ≥2; `AW = $clog2(NREGS)`
- `NRP`, 2, number of read ports, 1..4
- `BYPASS`, 1, 1 = a same-cycle core write is forwarded to matching read ports; 0 = reads return stored value
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rd_addr`  in  NRP×AW  read addresses
- `rd_data`  out  NRP×XLEN  combinational read data
- `rd_busy`  out  NRP  busy bit of each read address
- `wr_en`  in  1  core write enable; also clears the busy bit of `wr_addr`
- `wr_addr`  in  AW  core write address
- `wr_data`  in  XLEN  core write data
- `busy_set`  in  1  mark `busy_addr` pending (load issued)
- `busy_addr`  in  AW  register to mark
- `dbg_req`  in  1  debug request, held high until `dbg_ack`
- `dbg_we`  in  1  1 = debug write, 0 = debug read; stable while `dbg_req` is high
- `dbg_addr`  in  AW  debug address; stable while `dbg_req` is high
- `dbg_wdata`  in  XLEN  debug write data
- `dbg_ack`  out  1  one-cycle completion pulse, registered
- `dbg_rdata`  out  XLEN  debug read data, valid while `dbg_ack` is high; holds its value afterwards

## Operation
- **x0 rules**
  - Register 0 always reads 0 and its `rd_busy` is always 0.
  - Core writes, debug writes and `busy_set` targeting address 0 are ignored.
- **Read path**
  - `rd_data[i] = mem[rd_addr[i]]`.
  - If `BYPASS=1`, `wr_en`, and `wr_addr==rd_addr[i]!=0`, then `rd_data[i]=wr_data`.
- **Busy query**
  - `rd_busy[i] = busy[rd_addr[i]]`.
  - If `BYPASS=1` and a matching core write is present this cycle, `rd_busy[i]=0`.
- **Busy update at each edge**
  - `wr_en` clears `busy[wr_addr]`; `busy_set` sets `busy[busy_addr]`.
  - Same address in the same cycle: set wins, so the bit ends at 1.
  - Debug writes never change busy bits.
- **Debug FSM**, states `IDLE`, `ACK`, `HOLD`:
  - `IDLE`: when `dbg_req & !wr_en`, grant at the edge.
    - If `dbg_we`, write `dbg_wdata` to `mem[dbg_addr]`; otherwise capture `mem[dbg_addr]` (pre-edge value) into `dbg_rdata`.
    - Go to `ACK`.
    - If `wr_en` is high, remain in `IDLE`. The core always has priority; there is no timeout, and starvation under continuous `wr_en` is permitted.
  - `ACK`: `dbg_ack=1` for exactly this cycle. Go to `HOLD` if `dbg_req` is still high, else `IDLE`.
  - `HOLD`: wait for `dbg_req=0`, then go to `IDLE`. No new grant can occur until `dbg_req` has dropped.
  - A debug read granted in the same cycle as a core write to the same address cannot happen, because grant requires `!wr_en`.

## Timing
- Read and busy query: 0-cycle (combinational).
- Core write: visible on read ports the cycle after the edge, or the same cycle with `BYPASS=1`.
- Debug access:
  - `dbg_req` high before edge N with `wr_en=0` → `dbg_ack` high in cycle N→N+1.
  - Minimum latency 1 cycle from request to ack.
  - Back-to-back requests need at least 1 idle cycle with `dbg_req` low.
- Reset (asynchronous, immediate): all registers 0, all busy bits 0, FSM `IDLE`, `dbg_ack=0`, `dbg_rdata=0`.
- Reset mid-handshake drops `dbg_ack` immediately and abandons the request.
- A debug write is committed only if the grant edge occurred before reset.

## Structure
- `reg_file_pkg`: the `dbg_state_t` enum (`IDLE`, `ACK`, `HOLD`) and the `REG_ZERO` address constant.
- Sub-module `reg_file_dbg_fsm`:
  - Inputs: `dbg_req`, `wr_en`.
  - Outputs: grant pulse and `dbg_ack`.
  - The parent owns storage, busy bits and the `dbg_rdata` capture.

## Test plan
- Reset, then `wr_en` x3←10; next cycle `rd_addr[0]=3` → `rd_data[0]=10`. Writing 77 to x0 → reads 0.
- `BYPASS=1`: `wr_en` x5←42 while `rd_addr[1]=5` in the same cycle → `rd_data[1]=42` combinationally. With `BYPASS=0`, the same stimulus reads the old value 0.
- Busy bits:
  - `busy_set` x7 → `rd_busy=1` next cycle.
  - `wr_en` x7←5 → `rd_busy=0` that cycle (`BYPASS=1`) and 0 after the edge.
  - Simultaneous `busy_set` x7 and `wr_en` x7 → busy stays 1.
- Debug write x9←60, then debug read x9:
  - Each access gives `dbg_ack` exactly 1 cycle after grant.
  - The read returns `dbg_rdata=60`; core `rd_data` of x9 = 60.
- `dbg_req` held while `wr_en` is high for 3 cycles → no grant; `dbg_ack` appears 1 cycle after `wr_en` drops.
- Debug req granted, `rst_n` pulsed low during the `ACK` cycle → `dbg_ack=0` immediately, FSM `IDLE`, all registers and busy bits 0.
